// File: rtl/alu_arbiter_if.sv
// Requester, result and ALU-subsystem signals shared by alu_arbiter and its environment.
// slave = arbiter side; master = requesters plus the ALU subsystem.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             Req0, Req1;
  logic [WIDTH-1:0] A0, A1, B0, B1;
  logic [2:0]       Op0, Op1;
  logic             SrcA0, SrcA1;
  logic [1:0]       SrcB0, SrcB1;
  logic             ZESE0, ZESE1;

  logic             Grant0, Grant1, Done0, Done1, Busy;
  logic [WIDTH-1:0] Result;
  logic             EQ_Q, GR_Q, LT_Q, Zero_Q, Ovfl_Q;

  logic [WIDTH-1:0] ALU_A, ALU_B;
  logic [2:0]       ALU_Op;
  logic             ALU_SrcA, ALU_ZE_SE;
  logic [1:0]       ALU_SrcB;
  logic [WIDTH-1:0] ALU_Out;
  logic             EQ, GR, LT, Zero, Ovfl;

  modport slave (
    input  Req0, Req1, A0, A1, B0, B1, Op0, Op1, SrcA0, SrcA1, SrcB0, SrcB1, ZESE0, ZESE1,
    output Grant0, Grant1, Done0, Done1, Busy,
    output Result, EQ_Q, GR_Q, LT_Q, Zero_Q, Ovfl_Q,
    output ALU_A, ALU_B, ALU_Op, ALU_SrcA, ALU_ZE_SE, ALU_SrcB,
    input  ALU_Out, EQ, GR, LT, Zero, Ovfl
  );

  modport master (
    output Req0, Req1, A0, A1, B0, B1, Op0, Op1, SrcA0, SrcA1, SrcB0, SrcB1, ZESE0, ZESE1,
    input  Grant0, Grant1, Done0, Done1, Busy,
    input  Result, EQ_Q, GR_Q, LT_Q, Zero_Q, Ovfl_Q,
    input  ALU_A, ALU_B, ALU_Op, ALU_SrcA, ALU_ZE_SE, ALU_SrcB,
    output ALU_Out, EQ, GR, LT, Zero, Ovfl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters; Grant 1 cycle after Req, Done LATENCY+2 after.
// Requesters hold Req until Done; one op in flight, new requests wait in IDLE (LATENCY+3 cycles/op).
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             srca;
    logic [1:0]       srcb;
    logic             zese;
  } opnd_t;

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state;
  logic          ptr;
  logic          winner;
  logic [CW-1:0] cnt;

  opnd_t req0_op, req1_op, win_op;
  logic  both, pick;

  always_comb begin
    req0_op = '{a: bus.A0, b: bus.B0, op: bus.Op0, srca: bus.SrcA0, srcb: bus.SrcB0, zese: bus.ZESE0};
    req1_op = '{a: bus.A1, b: bus.B1, op: bus.Op1, srca: bus.SrcA1, srcb: bus.SrcB1, zese: bus.ZESE1};
    both    = bus.Req0 & bus.Req1;
    // The pointer only breaks ties; a lone requester always wins.
    pick    = both ? ptr : bus.Req1;
    win_op  = pick ? req1_op : req0_op;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      winner        <= 1'b0;
      cnt           <= '0;
      bus.Grant0    <= 1'b0;
      bus.Grant1    <= 1'b0;
      bus.Done0     <= 1'b0;
      bus.Done1     <= 1'b0;
      bus.Busy      <= 1'b0;
      bus.Result    <= '0;
      bus.EQ_Q      <= 1'b0;
      bus.GR_Q      <= 1'b0;
      bus.LT_Q      <= 1'b0;
      bus.Zero_Q    <= 1'b0;
      bus.Ovfl_Q    <= 1'b0;
      bus.ALU_A     <= '0;
      bus.ALU_B     <= '0;
      bus.ALU_Op    <= '0;
      bus.ALU_SrcA  <= 1'b0;
      bus.ALU_SrcB  <= '0;
      bus.ALU_ZE_SE <= 1'b0;
    end else begin
      bus.Grant0 <= 1'b0;
      bus.Grant1 <= 1'b0;
      bus.Done0  <= 1'b0;
      bus.Done1  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Req0 | bus.Req1) begin
            winner        <= pick;
            if (both) ptr <= ~pick;
            bus.ALU_A     <= win_op.a;
            bus.ALU_B     <= win_op.b;
            bus.ALU_Op    <= win_op.op;
            bus.ALU_SrcA  <= win_op.srca;
            bus.ALU_SrcB  <= win_op.srcb;
            bus.ALU_ZE_SE <= win_op.zese;
            bus.Grant0    <= ~pick;
            bus.Grant1    <= pick;
            bus.Busy      <= 1'b1;
            cnt           <= CW'(LATENCY - 1);
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) state <= CAPT;
          else           cnt   <= cnt - CW'(1);
        end
        CAPT: begin
          bus.Result <= bus.ALU_Out;
          bus.EQ_Q   <= bus.EQ;
          bus.GR_Q   <= bus.GR;
          bus.LT_Q   <= bus.LT;
          bus.Zero_Q <= bus.Zero;
          bus.Ovfl_Q <= bus.Ovfl;
          bus.Done0  <= ~winner;
          bus.Done1  <= winner;
          state      <= DONE;
        end
        DONE: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal checks plus randomized traffic against a schedule-based model.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int L1 = 1;
  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();
  alu_arbiter_if #(.WIDTH(W)) bus2 ();

  alu_arbiter #(.WIDTH(W), .LATENCY(L1)) dut  (.Clock(clk), .Reset(rst),  .bus(bus));
  alu_arbiter #(.WIDTH(W), .LATENCY(L2)) dut2 (.Clock(clk), .Reset(rst2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic eq, gr, lt, zero, ovfl;
  } alu_t;

  function automatic alu_t alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    alu_t r;
    logic [W-1:0] y;
    y = '0;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << 1;
      3'd6: y = a >> 1;
      default: y = a - b;
    endcase
    r.res  = y;
    r.eq   = (a == b);
    r.gr   = (a > b);
    r.lt   = (a < b);
    r.zero = (y == '0);
    if (op == 3'd0)                    r.ovfl = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
    else if (op == 3'd1 || op == 3'd7) r.ovfl = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
    else                               r.ovfl = 1'b0;
    return r;
  endfunction

  // Registered ALU subsystems, LATENCY edges deep.
  alu_t pipe1 [L1];
  alu_t pipe2 [L2];
  initial begin
    for (int i = 0; i < L1; i++) pipe1[i] = '0;
    for (int i = 0; i < L2; i++) pipe2[i] = '0;
  end
  always @(posedge clk) begin
    pipe1[0] <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_Op);
    for (int i = 1; i < L1; i++) pipe1[i] <= pipe1[i-1];
    pipe2[0] <= alu_f(bus2.ALU_A, bus2.ALU_B, bus2.ALU_Op);
    for (int i = 1; i < L2; i++) pipe2[i] <= pipe2[i-1];
  end
  assign {bus.ALU_Out, bus.EQ, bus.GR, bus.LT, bus.Zero, bus.Ovfl}       = pipe1[L1-1];
  assign {bus2.ALU_Out, bus2.EQ, bus2.GR, bus2.LT, bus2.Zero, bus2.Ovfl} = pipe2[L2-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op started at edge k shows Grant after edge k, captures and pulses
  // Done after edge k+L+1, is Busy through edge k+L+1, and frees arbitration at k+L+3.
  bit              mvalid = 1'b0;
  int              ecnt, k;
  bit              active, mwin, mptr;
  logic [2*W+6:0]  mopnd;
  logic [4:0]      exp_ctrl;
  alu_t            exp_res;

  always @(posedge clk) begin
    if (rst) begin
      mvalid   = 1'b1;
      ecnt     = 0;
      active   = 1'b0;
      mptr     = 1'b0;
      mopnd    = '0;
      exp_res  = '0;
      exp_ctrl = '0;
    end else if (mvalid) begin
      ecnt++;
      if (!active || ecnt >= k + L1 + 3) begin
        active = 1'b0;
        if (bus.Req0 || bus.Req1) begin
          if (bus.Req0 && bus.Req1) begin
            mwin = mptr;
            mptr = !mptr;
          end else begin
            mwin = bus.Req1;
          end
          active = 1'b1;
          k      = ecnt;
          mopnd  = mwin ? {bus.A1, bus.B1, bus.Op1, bus.SrcA1, bus.SrcB1, bus.ZESE1}
                        : {bus.A0, bus.B0, bus.Op0, bus.SrcA0, bus.SrcB0, bus.ZESE0};
        end
      end
      if (active && ecnt == k + L1 + 1)
        exp_res = alu_f(mopnd[2*W+6 -: W], mopnd[W+6 -: W], mopnd[6:4]);
      exp_ctrl = {active && ecnt == k && !mwin,
                  active && ecnt == k && mwin,
                  active && ecnt == k + L1 + 1 && !mwin,
                  active && ecnt == k + L1 + 1 && mwin,
                  active && ecnt <= k + L1 + 1};
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ctrl", 64'({bus.Grant0, bus.Grant1, bus.Done0, bus.Done1, bus.Busy}), 64'(exp_ctrl));
      check("result_flags", 64'({bus.Result, bus.EQ_Q, bus.GR_Q, bus.LT_Q, bus.Zero_Q, bus.Ovfl_Q}), 64'(exp_res));
      check("alu_drive", 64'({bus.ALU_A, bus.ALU_B, bus.ALU_Op, bus.ALU_SrcA, bus.ALU_SrcB, bus.ALU_ZE_SE}), 64'(mopnd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic sa, input logic [1:0] sb, input logic ze);
    bus.A0 = a; bus.B0 = b; bus.Op0 = op; bus.SrcA0 = sa; bus.SrcB0 = sb; bus.ZESE0 = ze;
  endtask

  task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic sa, input logic [1:0] sb, input logic ze);
    bus.A1 = a; bus.B1 = b; bus.Op1 = op; bus.SrcA1 = sa; bus.SrcB1 = sb; bus.ZESE1 = ze;
  endtask

  int grants [4];
  int ng;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    set0('0, '0, '0, 1'b0, '0, 1'b0);
    set1('0, '0, '0, 1'b0, '0, 1'b0);
    bus2.Req0 = 1'b0; bus2.Req1 = 1'b0;
    bus2.A0 = '0; bus2.B0 = '0; bus2.Op0 = '0; bus2.SrcA0 = 1'b0; bus2.SrcB0 = '0; bus2.ZESE0 = 1'b0;
    bus2.A1 = '0; bus2.B1 = '0; bus2.Op1 = '0; bus2.SrcA1 = 1'b0; bus2.SrcB1 = '0; bus2.ZESE1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0; rst2 = 1'b0;

    check("reset_ctrl", 64'({bus.Grant0, bus.Grant1, bus.Done0, bus.Done1, bus.Busy}), 64'd0);
    check("reset_result", 64'(bus.Result), 64'd0);
    check("reset_alu_a", 64'(bus.ALU_A), 64'd0);

    // 10+5 from requester 0; A0 changed after grant must not matter.
    set0(16'd10, 16'd5, 3'd0, 1'b1, 2'd0, 1'b0);
    bus.Req0 = 1'b1;
    tick();
    check("add_grant0", 64'({bus.Grant0, bus.Grant1}), 64'b10);
    check("add_alu_a", 64'(bus.ALU_A), 64'd10);
    bus.A0 = 16'd99;
    bus.Req0 = 1'b0;
    tick();
    check("add_no_done_yet", 64'({bus.Done0, bus.Done1}), 64'b00);
    tick();
    check("add_done0", 64'({bus.Done0, bus.Done1, bus.Grant0}), 64'b100);
    check("add_result", 64'(bus.Result), 64'd15);
    tick();
    check("add_idle", 64'(bus.Busy), 64'd0);

    // Compare 2 vs 1, then 2 vs 2, from requester 1.
    set1(16'd2, 16'd1, 3'd7, 1'b0, 2'd1, 1'b1);
    bus.Req1 = 1'b1;
    tick();
    check("cmp_grant1", 64'({bus.Grant0, bus.Grant1}), 64'b01);
    bus.Req1 = 1'b0;
    tick(); tick();
    check("cmp_done1", 64'({bus.Done0, bus.Done1}), 64'b01);
    check("cmp_gt_flags", 64'({bus.EQ_Q, bus.GR_Q, bus.LT_Q}), 64'b010);
    tick();
    bus.B1 = 16'd2;
    bus.Req1 = 1'b1;
    tick();
    bus.Req1 = 1'b0;
    tick(); tick();
    check("cmp_eq_flags", 64'({bus.Done1, bus.EQ_Q, bus.GR_Q, bus.LT_Q}), 64'b1100);
    tick();

    // Both held from just after reset: grants must alternate starting with 0.
    rst = 1'b1; tick(); rst = 1'b0;
    set0(16'd1, 16'd2, 3'd0, 1'b0, 2'd0, 1'b0);
    set1(16'd7, 16'd3, 3'd1, 1'b1, 2'd2, 1'b0);
    bus.Req0 = 1'b1; bus.Req1 = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (bus.Grant0) begin grants[ng] = 0; ng++; end
      else if (bus.Grant1) begin grants[ng] = 1; ng++; end
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    check("rr_grant_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < ng) check("rr_order", 64'(grants[i]), 64'(i % 2));
    for (int c = 0; c < 10 && bus.Busy; c++) tick();
    tick();

    // Reset while in EXEC aborts the op with no Done.
    set0(16'd10, 16'd5, 3'd0, 1'b1, 2'd0, 1'b0);
    bus.Req0 = 1'b1;
    tick();
    bus.Req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", 64'({bus.Grant0, bus.Grant1, bus.Done0, bus.Done1, bus.Busy}), 64'd0);
    check("abort_result", 64'(bus.Result), 64'd0);
    check("abort_alu_a", 64'(bus.ALU_A), 64'd0);
    tick(); tick();
    check("abort_no_done", 64'({bus.Done0, bus.Done1}), 64'b00);

    // LATENCY=2 instance: Done0 one cycle later.
    bus2.A0 = 16'd10; bus2.B0 = 16'd5; bus2.Op0 = 3'd0; bus2.SrcA0 = 1'b1;
    bus2.Req0 = 1'b1;
    tick();
    check("l2_grant0", 64'(bus2.Grant0), 64'd1);
    bus2.Req0 = 1'b0;
    tick();
    check("l2_no_done_a", 64'(bus2.Done0), 64'd0);
    tick();
    check("l2_no_done_b", 64'(bus2.Done0), 64'd0);
    tick();
    check("l2_done0", 64'(bus2.Done0), 64'd1);
    check("l2_result", 64'(bus2.Result), 64'd15);

    // Random traffic with occasional resets; operands churn every cycle.
    for (int c = 0; c < 3000; c++) begin
      bus.Req0 = ($urandom_range(0, 99) < 45);
      bus.Req1 = ($urandom_range(0, 99) < 45);
      set0(W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom), 3'($urandom),
           1'($urandom), 2'($urandom), 1'($urandom));
      set1(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
